// File: rtl/tile_dma_pkg.sv
// Shared definitions for the tile-attribute DMA: register map, CTRL bits, FSM states.
package tile_dma_pkg;

    // Tile-attribute RAM in the video unit holds 512 byte entries.
    localparam int unsigned TATTR_AW_DEFAULT = 9;
    localparam int unsigned LEN_W_DEFAULT    = 10;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_ABORT_BIT = 1;
    localparam int unsigned CTRL_BUSY_BIT  = 0;
    localparam int unsigned CTRL_DONE_BIT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/tile_dma.sv
// Copies LEN bytes from word-addressed memory into the tile-attribute RAM,
// one byte per cycle, lane 0 first, with abort and completion interrupt.
module tile_dma
    import tile_dma_pkg::*;
#(
    parameter int unsigned TATTR_AW = TATTR_AW_DEFAULT,
    parameter int unsigned LEN_W    = LEN_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          cfg_addr,
    input  logic [31:0]         cfg_wdata,
    input  logic                cfg_wenable,
    output logic [31:0]         cfg_rdata,
    output logic [31:0]         mem_addr,
    output logic                mem_req,
    input  logic                mem_ready,
    input  logic [31:0]         mem_rdata,
    output logic [TATTR_AW-1:0] tattr_addr,
    output logic [7:0]          tattr_wdata,
    output logic                tattr_wenable,
    output logic                irq_done
);

    state_t              state;
    logic [29:0]         src_reg;
    logic [TATTR_AW-1:0] dst_reg;
    logic [LEN_W-1:0]    len_reg;
    logic                done;

    logic [29:0]         w_src;
    logic [TATTR_AW-1:0] w_dst;
    logic [LEN_W-1:0]    w_rem;
    logic [31:0]         word;
    logic [1:0]          lane;

    logic ctrl_wr;
    logic start;
    logic abort;
    logic busy;
    logic [7:0] lane_byte;

    assign ctrl_wr = cfg_wenable && (cfg_addr == REG_CTRL);
    assign start   = ctrl_wr && cfg_wdata[CTRL_START_BIT];
    assign abort   = ctrl_wr && cfg_wdata[CTRL_ABORT_BIT];
    assign busy    = (state != ST_IDLE);

    // Register readback
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            REG_SRC:  cfg_rdata = {src_reg, 2'b00};
            REG_DST:  cfg_rdata = 32'(dst_reg);
            REG_LEN:  cfg_rdata = 32'(len_reg);
            default: begin
                cfg_rdata[CTRL_DONE_BIT] = done;
                cfg_rdata[CTRL_BUSY_BIT] = busy;
            end
        endcase
    end

    // Byte-lane select from the captured source word
    always_comb begin
        lane_byte = word[7:0];
        case (lane)
            2'd1:    lane_byte = word[15:8];
            2'd2:    lane_byte = word[23:16];
            2'd3:    lane_byte = word[31:24];
            default: lane_byte = word[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            src_reg       <= '0;
            dst_reg       <= '0;
            len_reg       <= '0;
            done          <= 1'b0;
            w_src         <= '0;
            w_dst         <= '0;
            w_rem         <= '0;
            word          <= '0;
            lane          <= '0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            tattr_wenable <= 1'b0;
            tattr_addr    <= '0;
            tattr_wdata   <= '0;
            irq_done      <= 1'b0;
        end else begin
            // Programmed registers only change while idle
            if (cfg_wenable && !busy) begin
                case (cfg_addr)
                    REG_SRC: src_reg <= cfg_wdata[31:2];
                    REG_DST: dst_reg <= cfg_wdata[TATTR_AW-1:0];
                    REG_LEN: len_reg <= cfg_wdata[LEN_W-1:0];
                    default: ;
                endcase
            end

            tattr_wenable <= 1'b0;
            irq_done      <= 1'b0;

            // Abort outranks start and any read acceptance in the same cycle
            if (abort) begin
                state   <= ST_IDLE;
                mem_req <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            done  <= 1'b0;
                            w_src <= src_reg;
                            w_dst <= dst_reg;
                            w_rem <= len_reg;
                            if (len_reg != '0) begin
                                state    <= ST_FETCH;
                                mem_req  <= 1'b1;
                                mem_addr <= {src_reg, 2'b00};
                            end else begin
                                state    <= ST_DONE;
                                irq_done <= 1'b1;
                                done     <= 1'b1;
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (mem_ready) begin
                            word          <= mem_rdata;
                            w_src         <= w_src + 30'd1;
                            mem_req       <= 1'b0;
                            state         <= ST_WRITE;
                            tattr_wenable <= 1'b1;
                            tattr_wdata   <= mem_rdata[7:0];
                            tattr_addr    <= w_dst;
                            w_dst         <= w_dst + TATTR_AW'(1);
                            w_rem         <= w_rem - LEN_W'(1);
                            lane          <= 2'd1;
                        end
                    end
                    ST_WRITE: begin
                        if (w_rem == '0) begin
                            state    <= ST_DONE;
                            irq_done <= 1'b1;
                            done     <= 1'b1;
                        end else if (lane == 2'd0) begin
                            state    <= ST_FETCH;
                            mem_req  <= 1'b1;
                            mem_addr <= {w_src, 2'b00};
                        end else begin
                            tattr_wenable <= 1'b1;
                            tattr_wdata   <= lane_byte;
                            tattr_addr    <= w_dst;
                            w_dst         <= w_dst + TATTR_AW'(1);
                            w_rem         <= w_rem - LEN_W'(1);
                            lane          <= lane + 2'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/tile_dma.md
TILE_DMA -- requirements
Module: tile_dma

Interface
REQ-001 Parameter: TATTR_AW, 9, tile-attribute RAM byte-address width (512 entries).
REQ-002 Parameter: LEN_W, 10, transfer-length width in bytes.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port: clk  input  1  system/write clock (same domain as tile-attribute RAM write port).
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: cfg_addr  input  2  register select: 0 SRC, 1 DST, 2 LEN, 3 CTRL.
REQ-007 Port: cfg_wdata  input  32  register write data.
REQ-008 Port: cfg_wenable  input  1  register write strobe.
REQ-009 Port: cfg_rdata  output  32  combinational readback of selected register.
REQ-010 Port: mem_addr  output  32  word-aligned source read address.
REQ-011 Port: mem_req  output  1  read request, held until accepted.
REQ-012 Port: mem_ready  input  1  read accepted; mem_rdata valid this cycle.
REQ-013 Port: mem_rdata  input  32  source word, little-endian bytes.
REQ-014 Port: tattr_addr  output  TATTR_AW  tile-attribute write address.
REQ-015 Port: tattr_wdata  output  8  tile-attribute write byte.
REQ-016 Port: tattr_wenable  output  1  tile-attribute write strobe.
REQ-017 Port: irq_done  output  1  one-cycle completion pulse.

Function
REQ-018 Registers SHALL be: SRC[31:2] (bits 1:0 read 0), DST[TATTR_AW-1:0], LEN[LEN_W-1:0]; unused bits read 0.
REQ-019 CTRL write SHALL decode bit0 = start, bit1 = abort; CTRL read SHALL return {30'b0, done, busy}.
REQ-020 Writes to SRC/DST/LEN while busy SHALL be ignored; start while busy SHALL be ignored.
REQ-021 States SHALL be IDLE, FETCH, WRITE, DONE; busy = (state != IDLE).
REQ-022 IDLE: start with LEN != 0 -> FETCH next cycle, clears done, latches working src/dst/remaining from registers; start with LEN == 0 -> DONE directly.
REQ-023 FETCH: mem_req = 1, mem_addr = working src; on mem_ready capture mem_rdata, src += 4, -> WRITE.
REQ-024 WRITE: one byte per cycle, byte lane 0 first; tattr_wenable = 1, tattr_addr = working dst, dst += 1 mod 2^TATTR_AW, remaining -= 1.
REQ-025 WRITE exit: remaining reaches 0 -> DONE (partial final word, remaining bytes discarded); 4 bytes emitted with remaining > 0 -> FETCH.
REQ-026 DONE: irq_done = 1 for exactly that cycle, done flag set, -> IDLE.
REQ-027 Latency: start in cycle N -> mem_req high in N+1; mem_ready in cycle M -> first tattr_wenable in M+1.
REQ-028 Abort SHALL return to IDLE next cycle from any state; no further mem_req/tattr_wenable; done not set; no irq_done.
REQ-029 Start and abort in the same write SHALL resolve to abort.
REQ-030 mem_ready coinciding with abort SHALL discard the data.
REQ-031 Programmed registers SHALL be unaffected by the transfer (working copies only), so restart repeats the identical transfer.
REQ-032 tattr_wenable, mem_req, irq_done SHALL be 0 outside FETCH/WRITE/DONE respectively.

Reset
REQ-033 On rst: state IDLE, all registers and working counters 0, done 0, mem_req 0, mem_addr 0, tattr_wenable 0, tattr_addr 0, tattr_wdata 0, irq_done 0.
REQ-034 rst mid-transfer SHALL abandon the transfer immediately with no further RAM writes.

Structure
REQ-035 Shared header SHALL hold register offsets, CTRL bit positions and state encodings; TATTR_AW default matches the video unit's tile-attribute RAM depth.
REQ-036 Single module, no sub-module; byte-lane select is a local mux.

Verification
REQ-037 SRC=0x100, DST=0, LEN=4, mem returns 0x44332211 -> writes 0x11,0x22,0x33,0x44 at 0..3 on consecutive cycles, one irq_done, CTRL reads 0b10.
REQ-038 LEN=6, DST=0x1FE -> two fetches (0x100, 0x104), writes to 0x1FE,0x1FF,0x000,0x001,0x002,0x003, then DONE.
REQ-039 mem_ready held low 5 cycles -> mem_req and mem_addr stable, no tattr_wenable until ready.
REQ-040 Abort during WRITE after 2 bytes -> no further wenable, busy 0 next cycle, done 0, no irq_done.
REQ-041 LEN=0 start -> no mem_req, irq_done one cycle later; start and SRC write while busy -> ignored, SRC readback unchanged.
REQ-042 rst asserted during FETCH -> all outputs 0 asynchronously, CTRL reads 0 after release.
